// File: rtl/pokey_keypad_scanner.sv
// -----------------------------------------------------------------------------
// pokey_keypad_scanner
//
// Keypad scan sequencer for the POKEY IO section. A 4-bit scan index steps
// once every DWELL cycles. Its inverse drives the column demux ([3:2]) and the
// row mux select ([1:0]). The muxed row return is sampled once per scan
// position, on the last dwell cycle. A four-state machine turns those samples
// into an accepted keycode, a one-cycle acceptance pulse and a key-down status.
//
// Parameters
//   DWELL        clk179 cycles spent at each scan position (must be >= 2)
//
// Ports
//   clk179       in   1  system clock, rising edge
//   rst_L        in   1  synchronous active-low reset
//   scan_en      in   1  keyboard scan enable (SKCTL[1])
//   debounce_en  in   1  debounce enable (SKCTL[0])
//   kr1_L        in   1  muxed row return, 0 = key at current position pressed
//   key_scan_L   out  4  inverted scan index
//   keycode      out  4  scan index of the last accepted key
//   key_pending  out  1  one-cycle pulse on key acceptance
//   key_down     out  1  high while the accepted key is held
// -----------------------------------------------------------------------------
module pokey_keypad_scanner #(
   parameter int unsigned DWELL = 114
) (
   input  logic       clk179,
   input  logic       rst_L,
   input  logic       scan_en,
   input  logic       debounce_en,
   input  logic       kr1_L,
   output logic [3:0] key_scan_L,
   output logic [3:0] keycode,
   output logic       key_pending,
   output logic       key_down
);

   localparam int unsigned CNT_W = (DWELL > 2) ? $clog2(DWELL) : 1;
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CONFIRM,
      ST_HELD,
      ST_RELEASE
   } state_t;

   logic [CNT_W-1:0] dwell_q, dwell_d;
   logic [3:0]       idx_q, idx_d;
   state_t           state_q, state_d;
   logic [3:0]       cand_q, cand_d;
   logic [3:0]       keycode_q, keycode_d;
   logic             pend_q, pend_d;
   logic             down_q, down_d;

   logic             sample;
   logic             pressed;

   // ---------------------------------------------------------------------------
   // Scan counter and debounce state machine, next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      sample    = (dwell_q == DWELL_LAST);
      pressed   = ~kr1_L;

      dwell_d   = dwell_q + 1'b1;
      idx_d     = idx_q;
      state_d   = state_q;
      cand_d    = cand_q;
      keycode_d = keycode_q;
      pend_d    = 1'b0;

      if (sample) begin
         dwell_d = '0;
         idx_d   = idx_q + 4'd1;

         case (state_q)
            ST_IDLE: begin
               // Positions are visited in order, so the first pressed one wins.
               if (pressed) begin
                  if (debounce_en) begin
                     cand_d  = idx_q;
                     state_d = ST_CONFIRM;
                  end else begin
                     keycode_d = idx_q;
                     pend_d    = 1'b1;
                     state_d   = ST_HELD;
                  end
               end
            end

            ST_CONFIRM: begin
               // A full pass later the same position must still read pressed.
               if (idx_q == cand_q) begin
                  if (pressed) begin
                     keycode_d = cand_q;
                     pend_d    = 1'b1;
                     state_d   = ST_HELD;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end

            ST_HELD: begin
               if ((idx_q == keycode_q) && !pressed) begin
                  state_d = debounce_en ? ST_RELEASE : ST_IDLE;
               end
            end

            ST_RELEASE: begin
               // Re-press returns to HELD without a second acceptance pulse.
               if (idx_q == keycode_q) begin
                  state_d = pressed ? ST_HELD : ST_IDLE;
               end
            end

            default: state_d = ST_IDLE;
         endcase
      end

      down_d = (state_d == ST_HELD) || (state_d == ST_RELEASE);
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk179) begin
      if (!rst_L) begin
         dwell_q   <= '0;
         idx_q     <= '0;
         state_q   <= ST_IDLE;
         cand_q    <= '0;
         keycode_q <= '0;
         pend_q    <= 1'b0;
         down_q    <= 1'b0;
      end else if (!scan_en) begin
         // Disabling freezes the scanner but keeps the last accepted keycode.
         dwell_q   <= '0;
         idx_q     <= '0;
         state_q   <= ST_IDLE;
         cand_q    <= '0;
         pend_q    <= 1'b0;
         down_q    <= 1'b0;
      end else begin
         dwell_q   <= dwell_d;
         idx_q     <= idx_d;
         state_q   <= state_d;
         cand_q    <= cand_d;
         keycode_q <= keycode_d;
         pend_q    <= pend_d;
         down_q    <= down_d;
      end
   end

   assign key_scan_L  = ~idx_q;
   assign keycode     = keycode_q;
   assign key_pending = pend_q;
   assign key_down    = down_q;

endmodule

// File: tb/tb_pokey_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_pokey_keypad_scanner
//
// Directed bench for pokey_keypad_scanner with DWELL=4. A 16-bit key matrix
// model answers the scan position with kr1_L. Cycle n is the interval before
// the n-th enabled clock edge. Values are sampled 1 time unit after each edge.
// -----------------------------------------------------------------------------
module tb_pokey_keypad_scanner;

   logic       clk179 = 1'b0;
   logic       rst_L = 1'b0;
   logic       scan_en = 1'b1;
   logic       debounce_en = 1'b0;
   logic       kr1_L = 1'b1;
   logic [3:0] key_scan_L;
   logic [3:0] keycode;
   logic       key_pending;
   logic       key_down;

   logic [15:0] keys = '0;
   int          cyc = 0;
   int          npulse = 0;
   int          last_pulse = -1;
   int          n_checks = 0;
   int          n_fail = 0;

   pokey_keypad_scanner #(.DWELL(4)) dut (
      .clk179      (clk179),
      .rst_L       (rst_L),
      .scan_en     (scan_en),
      .debounce_en (debounce_en),
      .kr1_L       (kr1_L),
      .key_scan_L  (key_scan_L),
      .keycode     (keycode),
      .key_pending (key_pending),
      .key_down    (key_down)
   );

   always #5 clk179 = ~clk179;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   // One clock: drive the row return for the current position, take the edge,
   // then record any acceptance pulse seen in the new cycle.
   task automatic step();
      logic [3:0] pos;
      @(negedge clk179);
      pos   = ~key_scan_L;
      kr1_L = ~keys[pos];
      @(posedge clk179);
      #1;
      cyc++;
      if (key_pending === 1'b1) begin
         npulse++;
         last_pulse = cyc;
      end
   endtask

   task automatic run_to(input int target);
      while (cyc < target) step();
   endtask

   task automatic do_reset();
      rst_L = 1'b0;
      @(posedge clk179);
      @(posedge clk179);
      #1;
      chk("rst_scan", 32'(key_scan_L), 32'hF);
      chk("rst_keycode", 32'(keycode), 32'h0);
      chk("rst_pending", 32'(key_pending), 32'h0);
      chk("rst_down", 32'(key_down), 32'h0);
      rst_L      = 1'b1;
      cyc        = 0;
      npulse     = 0;
      last_pulse = -1;
   endtask

   initial begin
      // Reset and plain scanning
      scan_en     = 1'b1;
      debounce_en = 1'b0;
      keys        = '0;
      do_reset();
      run_to(3);
      chk("scan_c3", 32'(key_scan_L), 32'hF);
      run_to(4);
      chk("scan_c4", 32'(key_scan_L), 32'hE);
      run_to(63);
      chk("scan_c63", 32'(key_scan_L), 32'h0);
      run_to(64);
      chk("scan_c64", 32'(key_scan_L), 32'hF);
      chk("scan_nopulse", 32'(npulse), 32'd0);

      // Debounced press of key 5, then debounced release
      debounce_en = 1'b1;
      do_reset();
      keys[5] = 1'b1;
      run_to(87);
      chk("db_pend_c87", 32'(key_pending), 32'h0);
      chk("db_down_c87", 32'(key_down), 32'h0);
      chk("db_code_c87", 32'(keycode), 32'h0);
      run_to(88);
      chk("db_pend_c88", 32'(key_pending), 32'h1);
      chk("db_code_c88", 32'(keycode), 32'h5);
      chk("db_down_c88", 32'(key_down), 32'h1);
      run_to(89);
      chk("db_pend_c89", 32'(key_pending), 32'h0);
      run_to(100);
      keys[5] = 1'b0;
      run_to(152);
      chk("rel_down_c152", 32'(key_down), 32'h1);
      run_to(215);
      chk("rel_down_c215", 32'(key_down), 32'h1);
      run_to(216);
      chk("rel_down_c216", 32'(key_down), 32'h0);
      chk("rel_code", 32'(keycode), 32'h5);
      chk("rel_npulse", 32'(npulse), 32'd1);

      // Re-press during release debounce (reset taken mid-HELD)
      do_reset();
      keys[5] = 1'b1;
      run_to(100);
      chk("rp_down_c100", 32'(key_down), 32'h1);
      keys[5] = 1'b0;
      run_to(160);
      keys[5] = 1'b1;
      run_to(216);
      chk("rp_down_c216", 32'(key_down), 32'h1);
      run_to(280);
      chk("rp_down_c280", 32'(key_down), 32'h1);
      chk("rp_npulse", 32'(npulse), 32'd1);

      // Glitch reject: key 5 only present during the first pass
      do_reset();
      keys = '0;
      keys[5] = 1'b1;
      run_to(40);
      keys[5] = 1'b0;
      run_to(100);
      chk("gl_npulse", 32'(npulse), 32'd0);
      chk("gl_down", 32'(key_down), 32'h0);
      chk("gl_code", 32'(keycode), 32'h0);

      // No debounce, keys 3 and 9 together
      debounce_en = 1'b0;
      do_reset();
      keys = '0;
      keys[3] = 1'b1;
      keys[9] = 1'b1;
      run_to(15);
      chk("nd_pend_c15", 32'(key_pending), 32'h0);
      run_to(16);
      chk("nd_pend_c16", 32'(key_pending), 32'h1);
      chk("nd_code_c16", 32'(keycode), 32'h3);
      run_to(40);
      chk("nd_npulse_c40", 32'(npulse), 32'd1);
      keys[3] = 1'b0;
      run_to(79);
      chk("nd_down_c79", 32'(key_down), 32'h1);
      run_to(80);
      chk("nd_down_c80", 32'(key_down), 32'h0);
      chk("nd_code_c80", 32'(keycode), 32'h3);
      run_to(104);
      chk("nd_pend_c104", 32'(key_pending), 32'h1);
      chk("nd_code_c104", 32'(keycode), 32'h9);
      chk("nd_down_c104", 32'(key_down), 32'h1);
      chk("nd_npulse_c104", 32'(npulse), 32'd2);
      chk("nd_last_pulse", 32'(last_pulse), 32'd104);

      // Disable while HELD on key 5, then re-enable
      do_reset();
      keys = '0;
      keys[5] = 1'b1;
      run_to(30);
      chk("dis_code_c30", 32'(keycode), 32'h5);
      chk("dis_down_c30", 32'(key_down), 32'h1);
      scan_en = 1'b0;
      step();
      chk("dis_scan", 32'(key_scan_L), 32'hF);
      chk("dis_down", 32'(key_down), 32'h0);
      chk("dis_code", 32'(keycode), 32'h5);
      step();
      step();
      chk("dis_frozen_scan", 32'(key_scan_L), 32'hF);
      scan_en    = 1'b1;
      cyc        = 0;
      npulse     = 0;
      last_pulse = -1;
      run_to(23);
      chk("ren_scan_c23", 32'(key_scan_L), 32'hA);
      chk("ren_pend_c23", 32'(key_pending), 32'h0);
      run_to(24);
      chk("ren_pend_c24", 32'(key_pending), 32'h1);
      chk("ren_down_c24", 32'(key_down), 32'h1);
      chk("ren_npulse", 32'(npulse), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pokey_keypad_scanner.md
# pokey_keypad_scanner

Keypad scan sequencer for the POKEY IO section: it steps the 4-bit keypad scan select that drives the column demux and row mux, and samples the muxed row return `kr1_L`. A debounce state machine turns raw row samples into a latched keycode, a one-cycle new-key pulse for IRQ/KBCODE logic, and a key-down status bit. It runs on the 1.79 MHz system clock and is configured from SKCTL.

## Interface
- `DWELL`, 114: clk179 cycles spent at each scan position; must be ≥ 2. The default gives ≈15.7 kHz per position.
- `clk179`  in  1  system clock; all logic is on its rising edge.
- `rst_L`  in  1  reset, synchronous and active-low.
- `scan_en`  in  1  keyboard scan enable (SKCTL[1]).
- `debounce_en`  in  1  debounce enable (SKCTL[0]).
- `kr1_L`  in  1  muxed row return; 0 means the key at the current scan position is pressed.
- `key_scan_L`  out  4  inverted scan index (~scan_idx). [3:2] feed the column demux; [1:0] feed the row mux select.
- `keycode`  out  4  latched scan index of the last accepted key.
- `key_pending`  out  1  one-cycle pulse when a key is accepted.
- `key_down`  out  1  1 while the accepted key is held (SKSTAT[2] source, active-high here).

## Operation
- **Scan counter**
  - `dwell_cnt` counts 0..DWELL-1, then wraps.
  - `scan_idx` (4 bits) increments on the cycle after `dwell_cnt` = DWELL-1, wrapping 15→0.
  - One full pass is 16·DWELL cycles.
- **Sample point**: `kr1_L` is sampled only on the cycle where `dwell_cnt` = DWELL-1 (the "sample at i" event, i = scan_idx). It is ignored on all other cycles.
- **States**
  - IDLE
    - Sample at i with kr1_L=0 and debounce_en=0: set `keycode` := i, pulse `key_pending`, go to HELD.
    - Sample at i with kr1_L=0 and debounce_en=1: `cand` := i, go to CONFIRM.
  - CONFIRM
    - Only the sample at `cand` is evaluated; the others are ignored.
    - Pressed: set `keycode` := cand, pulse `key_pending`, go to HELD.
    - Not pressed: go to IDLE.
  - HELD
    - `key_down`=1. Only the sample at `keycode` is evaluated.
    - Pressed: stay in HELD.
    - Released with debounce_en=1: go to RELEASE.
    - Released with debounce_en=0: go to IDLE.
  - RELEASE
    - `key_down` stays 1. Only the sample at `keycode` is evaluated.
    - Released: go to IDLE.
    - Pressed: go back to HELD, with no new pulse.
- **Multiple keys**: in IDLE, the first pressed position in scan order wins. No rollover: other keys are ignored in CONFIRM, HELD and RELEASE.
- **Outputs**
  - `keycode` holds its value after release and is only overwritten on acceptance.
  - `key_down` is 1 in HELD and RELEASE, 0 otherwise.
- **debounce_en change**: takes effect at the next evaluated sample.
- **scan_en=0**: synchronously clear `dwell_cnt`, `scan_idx`, state (to IDLE), `cand`, `key_pending` and `key_down`. `keycode` is retained. While low the block is frozen, with `key_scan_L`=4'hF.

## Timing
- **Reset (rst_L=0 at an edge)**: `key_scan_L`=4'hF, `keycode`=0, `key_pending`=0, `key_down`=0, state IDLE, both counters 0. Reset overrides `scan_en` and applies in any state, including mid-CONFIRM or mid-HELD.
- **Cycle numbering**: cycle 0 is the first edge with rst_L=1 and scan_en=1. Position i is sampled at cycle i·DWELL + DWELL-1 + k·16·DWELL.
- **Register timing**: state, `keycode`, `key_pending` and `key_down` update on the edge after the sample cycle. `key_scan_L` changes on the edge after the last dwell cycle.
- **Press latency** (sample-cycle to `key_pending` high)
  - Debounce off: 1 cycle.
  - Debounce on: 16·DWELL + 1 cycles after the first pressed sample.
- **Release latency**
  - Debounce on: `key_down` falls 16·DWELL + 1 cycles after the first released sample.
  - Debounce off: 1 cycle.
- **Pulse width**: `key_pending` is high for exactly 1 cycle per acceptance, never on consecutive cycles.

## Test plan
- **Reset/scan**: with DWELL=4, rst_L low for 2 cycles, then release → `key_scan_L`=F, `keycode`=0, `key_pending`=0, `key_down`=0. `key_scan_L`=E at cycle 4 and =F again at cycle 64.
- **Debounced press**: DWELL=4, debounce_en=1, kr1_L=0 whenever scan_idx=5 → `key_pending` high only at cycle 88 (sample 23, confirm 87). `keycode`=5 and `key_down`=1 from cycle 88.
- **Glitch reject**: key 5 pressed only during the first pass (released before cycle 87) → no `key_pending`, `key_down` stays 0, `keycode` stays 0.
- **Release debounce**: with key 5 held, release it before its sample at cycle 151 → `key_down` stays 1 through cycle 151 and falls at cycle 216. Re-pressing before cycle 215 instead keeps `key_down`=1 with no second pulse.
- **No debounce / multi-key**: debounce_en=0, keys 3 and 9 pressed → `key_pending` high at cycle 16 only, `keycode`=3. Releasing key 3 while 9 stays held makes `key_down` fall at cycle 80, then key 9 is accepted with a pulse at cycle 104.
- **Disable mid-operation**: in HELD with `keycode`=5, drop scan_en → next cycle `key_scan_L`=F and `key_down`=0, with `keycode` still 5. Re-enabling restarts from cycle 0 with the state in IDLE.
